// File: rtl/fddrip_ctrl_pkg.sv
// Shared definitions for the FDD flux ripper sequencer.
// Build switch: FDDRIP_IDX_FILT_EN enables the index glitch filter in fdd_index_det.
package fddrip_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WAIT_IDX = 3'd1,
        ST_CAPTURE  = 3'd2,
        ST_LATCH    = 3'd3,
        ST_FINISH   = 3'd4
    } state_e;

    localparam int TMO_W_DEF = 24;
    localparam int REV_W_DEF = 4;

`ifdef FDDRIP_IDX_FILT_EN
    localparam int IDX_FILT_LEN = 4;
    localparam int IDX_EDGE_LAT = 6;
`else
    localparam int IDX_EDGE_LAT = 3;
`endif

endpackage

// File: rtl/fdd_index_det.sv
// Index pulse detector: 2-flop synchroniser, optional low-level filter, registered falling-edge strobe.
// Build switch: FDDRIP_IDX_FILT_EN requires 4 consecutive low samples before the edge is reported.
module fdd_index_det
    import fddrip_ctrl_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic index_n,
    output logic idx_edge
);

    logic sync1_q, sync2_q;
    logic edge_q, edge_d;

    // Idle level of the index line is high, so the synchroniser resets to 1.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            edge_q  <= 1'b0;
        end else begin
            sync1_q <= index_n;
            sync2_q <= sync1_q;
            edge_q  <= edge_d;
        end
    end

`ifdef FDDRIP_IDX_FILT_EN
    logic [2:0] low_cnt_q, low_cnt_d;

    always_comb begin
        low_cnt_d = low_cnt_q;
        edge_d    = 1'b0;
        if (sync2_q) begin
            low_cnt_d = 3'd0;
        end else if (low_cnt_q != 3'(IDX_FILT_LEN)) begin
            low_cnt_d = low_cnt_q + 3'd1;
            edge_d    = (low_cnt_q == 3'(IDX_FILT_LEN - 1));
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) low_cnt_q <= 3'd0;
        else       low_cnt_q <= low_cnt_d;
    end
`else
    logic prev_q;

    always_comb edge_d = prev_q & ~sync2_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) prev_q <= 1'b1;
        else       prev_q <= sync2_q;
    end
`endif

    assign idx_edge = edge_q;

endmodule

// File: rtl/fddrip_ctrl.sv
// Flux ripper sequencer: arms on index, captures N revolutions, latches the byte count, reports status.
// Build switch: FDDRIP_IDX_FILT_EN (index glitch filter inside fdd_index_det).
module fddrip_ctrl
    import fddrip_ctrl_pkg::*;
#(
    parameter int TMO_W = TMO_W_DEF,
    parameter int REV_W = REV_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [REV_W-1:0] revs,
    input  logic             index_n,
    input  logic             dma_req,
    input  logic             rip_stb,
    output logic             rip_reset,
    output logic             rip_req,
    output logic             cnt_latch,
    output logic             busy,
    output logic             done,
    output logic             err_tmo,
    output logic             err_abort,
    output logic [REV_W-1:0] rev_cnt
);

    state_e             state_q, state_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic [REV_W-1:0]   target_q, target_d;
    logic [REV_W-1:0]   rev_cnt_q, rev_cnt_d;
    logic               done_q, done_d;
    logic               err_tmo_q, err_tmo_d;
    logic               err_abort_q, err_abort_d;
    logic               idx_edge;
    logic               tmo_hit;
    logic [REV_W-1:0]   rev_next;

    fdd_index_det u_index_det (
        .clk      (clk),
        .reset    (reset),
        .index_n  (index_n),
        .idx_edge (idx_edge)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            tmo_q       <= '0;
            target_q    <= '0;
            rev_cnt_q   <= '0;
            done_q      <= 1'b0;
            err_tmo_q   <= 1'b0;
            err_abort_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            tmo_q       <= tmo_d;
            target_q    <= target_d;
            rev_cnt_q   <= rev_cnt_d;
            done_q      <= done_d;
            err_tmo_q   <= err_tmo_d;
            err_abort_q <= err_abort_d;
        end
    end

    assign tmo_hit  = (tmo_q == '1);
    assign rev_next = rev_cnt_q + REV_W'(1);

    // Abort outranks an index edge, which outranks the timeout.
    always_comb begin
        state_d     = state_q;
        tmo_d       = tmo_q;
        target_d    = target_q;
        rev_cnt_d   = rev_cnt_q;
        done_d      = done_q;
        err_tmo_d   = err_tmo_q;
        err_abort_d = err_abort_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    done_d      = 1'b0;
                    err_tmo_d   = 1'b0;
                    err_abort_d = 1'b0;
                    rev_cnt_d   = '0;
                    target_d    = (revs == '0) ? REV_W'(1) : revs;
                    tmo_d       = '0;
                    state_d     = ST_WAIT_IDX;
                end
            end
            ST_WAIT_IDX, ST_CAPTURE: begin
                tmo_d = tmo_q + TMO_W'(1);
                if (abort) begin
                    err_abort_d = 1'b1;
                    state_d     = ST_LATCH;
                end else if (idx_edge) begin
                    tmo_d = '0;
                    if (state_q == ST_WAIT_IDX) begin
                        state_d = ST_CAPTURE;
                    end else begin
                        if (rev_cnt_q != target_q) rev_cnt_d = rev_next;
                        if (rev_next == target_q)  state_d   = ST_LATCH;
                    end
                end else if (tmo_hit) begin
                    err_tmo_d = 1'b1;
                    state_d   = ST_LATCH;
                end
            end
            ST_LATCH: begin
                if (abort) err_abort_d = 1'b1;
                state_d = ST_FINISH;
            end
            ST_FINISH: begin
                // done only marks a rip that ended without timeout or abort.
                if (abort)                          err_abort_d = 1'b1;
                else if (!err_tmo_q && !err_abort_q) done_d      = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        rip_reset = 1'b1;
        rip_req   = 1'b0;
        cnt_latch = 1'b0;
        busy      = 1'b1;
        case (state_q)
            ST_IDLE:    busy = 1'b0;
            ST_CAPTURE: begin
                rip_reset = 1'b0;
                rip_req   = dma_req;
            end
            ST_LATCH: begin
                rip_reset = 1'b0;
                cnt_latch = 1'b1;
            end
            default: ;
        endcase
    end

    assign done      = done_q;
    assign err_tmo   = err_tmo_q;
    assign err_abort = err_abort_q;
    assign rev_cnt   = rev_cnt_q;

    // The ripper may only strobe a byte against a live request.
    rip_stb_needs_req: assert property (@(posedge clk) disable iff (reset) rip_stb |-> rip_req);

endmodule

// File: tb/tb_fddrip_ctrl.sv
// Directed bench for fddrip_ctrl: normal rips, revs=0, timeout, abort on index edge, async reset, DMA gating.
module tb_fddrip_ctrl;

    localparam int TMO_W = 8;
    localparam int REV_W = 4;
`ifdef FDDRIP_IDX_FILT_EN
    localparam int IDX_LAT = 6;
`else
    localparam int IDX_LAT = 3;
`endif

    logic             clk, reset, start, abort, index_n, dma_req, rip_stb;
    logic [REV_W-1:0] revs;
    logic             rip_reset, rip_req, cnt_latch, busy, done, err_tmo, err_abort;
    logic [REV_W-1:0] rev_cnt;

    int n_checks = 0;
    int n_pass   = 0;
    logic [REV_W-1:0] exp_q[$];
    int n_wait;

    fddrip_ctrl #(.TMO_W(TMO_W), .REV_W(REV_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .abort     (abort),
        .revs      (revs),
        .index_n   (index_n),
        .dma_req   (dma_req),
        .rip_stb   (rip_stb),
        .rip_reset (rip_reset),
        .rip_req   (rip_req),
        .cnt_latch (cnt_latch),
        .busy      (busy),
        .done      (done),
        .err_tmo   (err_tmo),
        .err_abort (err_abort),
        .rev_cnt   (rev_cnt)
    );

    // Clock / watchdog
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish, checks=%0d passed=%0d", n_checks, n_pass);
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        else             n_pass++;
    endtask

    // Scoreboard: every cnt_latch pulse must match a queued expected revolution count.
    always @(negedge clk) begin
        if (!reset && cnt_latch) begin
            if (exp_q.size() == 0) check("latch_unexpected", 32'd1, 32'd0);
            else                   check("latch_rev", 32'(rev_cnt), 32'(exp_q.pop_front()));
        end
    end

    // Driver tasks
    task automatic tick(input int n = 1);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic pulse_start(input logic [REV_W-1:0] r);
        revs  = r;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Leaves index low with idx_edge presented to the FSM but not yet taken.
    task automatic idx_fall();
        index_n = 1'b0;
        tick(IDX_LAT);
    endtask

    task automatic idx_rise();
        tick(10);
        index_n = 1'b1;
        tick(60);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; abort = 1'b0; revs = '0;
        index_n = 1'b1; dma_req = 1'b1; rip_stb = 1'b0;
        tick(3);
        check("rst_rip_reset", 32'(rip_reset), 32'd1);
        check("rst_rip_req",   32'(rip_req),   32'd0);
        check("rst_cnt_latch", 32'(cnt_latch), 32'd0);
        check("rst_busy",      32'(busy),      32'd0);
        check("rst_done",      32'(done),      32'd0);
        check("rst_err_tmo",   32'(err_tmo),   32'd0);
        check("rst_err_abort", 32'(err_abort), 32'd0);
        check("rst_rev_cnt",   32'(rev_cnt),   32'd0);
        reset = 1'b0;
        tick(2);

        // Normal rip, revs=2, dma_req held high throughout
        pulse_start(4'd2);
        check("wait_busy",      32'(busy),      32'd1);
        check("wait_rip_reset", 32'(rip_reset), 32'd1);
        check("wait_rip_req",   32'(rip_req),   32'd0);
        tick(5);
        idx_fall();
        check("arm_not_yet", 32'(rip_reset), 32'd1);
        tick();
        check("arm_rip_reset", 32'(rip_reset), 32'd0);
        check("cap_rip_req",   32'(rip_req),   32'd1);
        check("cap_rev0",      32'(rev_cnt),   32'd0);
        dma_req = 1'b0;
        #1;
        check("cap_rip_req_gated", 32'(rip_req), 32'd0);
        dma_req = 1'b1;
        idx_rise();
        idx_fall();
        tick();
        check("cap_rev1",       32'(rev_cnt),   32'd1);
        check("cap_rip_reset1", 32'(rip_reset), 32'd0);
        idx_rise();
        exp_q.push_back(4'd2);
        idx_fall();
        tick();
        check("latch_pulse",     32'(cnt_latch), 32'd1);
        check("latch_rev2",      32'(rev_cnt),   32'd2);
        check("latch_rip_req",   32'(rip_req),   32'd0);
        check("latch_rip_reset", 32'(rip_reset), 32'd0);
        tick();
        check("fin_rip_reset", 32'(rip_reset), 32'd1);
        check("fin_cnt_latch", 32'(cnt_latch), 32'd0);
        check("fin_rip_req",   32'(rip_req),   32'd0);
        check("fin_busy",      32'(busy),      32'd1);
        check("fin_done",      32'(done),      32'd0);
        tick();
        check("norm_busy", 32'(busy),    32'd0);
        check("norm_done", 32'(done),    32'd1);
        check("norm_rev",  32'(rev_cnt), 32'd2);
        tick(10);
        index_n = 1'b1;
        tick(20);

        // Abort in IDLE is ignored
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("idle_abort_ign", 32'(err_abort), 32'd0);
        check("idle_abort_busy", 32'(busy),     32'd0);
        check("idle_abort_done", 32'(done),     32'd1);

        // revs=0 behaves as one revolution
        pulse_start(4'd0);
        check("r0_done_clr", 32'(done), 32'd0);
        tick(5);
        idx_fall();
        tick();
        check("r0_armed", 32'(rip_reset), 32'd0);
        idx_rise();
        exp_q.push_back(4'd1);
        idx_fall();
        tick();
        check("r0_latch", 32'(cnt_latch), 32'd1);
        check("r0_rev",   32'(rev_cnt),   32'd1);
        tick(2);
        check("r0_done", 32'(done), 32'd1);
        check("r0_busy", 32'(busy), 32'd0);
        tick(10);
        index_n = 1'b1;
        tick(20);

        // Timeout with no index: 2^TMO_W cycles in WAIT_IDX before LATCH
        exp_q.push_back(4'd0);
        pulse_start(4'd3);
        n_wait = 0;
        while (cnt_latch !== 1'b1 && n_wait < 400) begin
            tick();
            n_wait++;
        end
        check("tmo_cycles",    32'(n_wait),  32'd256);
        check("tmo_err",       32'(err_tmo), 32'd1);
        check("tmo_done_lat",  32'(done),    32'd0);
        tick(2);
        check("tmo_busy",  32'(busy),    32'd0);
        check("tmo_done",  32'(done),    32'd0);
        check("tmo_stick", 32'(err_tmo), 32'd1);

        // Abort in CAPTURE in the same cycle as an index edge
        pulse_start(4'd3);
        check("ab_tmo_clr", 32'(err_tmo), 32'd0);
        tick(5);
        idx_fall();
        tick();
        idx_rise();
        exp_q.push_back(4'd0);
        idx_fall();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("ab_err",     32'(err_abort), 32'd1);
        check("ab_rev",     32'(rev_cnt),   32'd0);
        check("ab_latch",   32'(cnt_latch), 32'd1);
        check("ab_rip_req", 32'(rip_req),   32'd0);
        tick();
        check("ab_fin_latch",   32'(cnt_latch), 32'd0);
        check("ab_fin_rip_req", 32'(rip_req),   32'd0);
        check("ab_fin_rst",     32'(rip_reset), 32'd1);
        tick();
        check("ab_busy",  32'(busy),      32'd0);
        check("ab_done",  32'(done),      32'd0);
        check("ab_stick", 32'(err_abort), 32'd1);
        tick(10);
        index_n = 1'b1;
        tick(20);

`ifdef FDDRIP_IDX_FILT_EN
        // A 3-cycle index glitch must not count as a revolution
        pulse_start(4'd3);
        tick(5);
        idx_fall();
        tick();
        idx_rise();
        index_n = 1'b0;
        tick(3);
        index_n = 1'b1;
        tick(12);
        check("glitch_rev",   32'(rev_cnt),   32'd0);
        check("glitch_armed", 32'(rip_reset), 32'd0);
        exp_q.push_back(4'd0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        tick(3);
`endif

        // Async reset in the middle of CAPTURE
        pulse_start(4'd3);
        tick(5);
        idx_fall();
        tick();
        idx_rise();
        idx_fall();
        tick();
        check("mid_rev1", 32'(rev_cnt), 32'd1);
        tick(5);
        #2 reset = 1'b1;
        #1;
        check("arst_rip_reset", 32'(rip_reset), 32'd1);
        check("arst_busy",      32'(busy),      32'd0);
        check("arst_rev",       32'(rev_cnt),   32'd0);
        check("arst_rip_req",   32'(rip_req),   32'd0);
        check("arst_cnt_latch", 32'(cnt_latch), 32'd0);
        tick();
        reset   = 1'b0;
        index_n = 1'b1;
        tick(20);
        check("post_rst_busy", 32'(busy), 32'd0);
        check("post_rst_done", 32'(done), 32'd0);

        check("latch_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
